// File: rtl/color_gen_param.sv
// color_gen_param: parametrised RGBW colour generator.
// Hue-wheel mapping, white saturation and shared-multiplier intensity scaling.
module color_gen_param #(
    parameter int         W           = 8,
    parameter int         SEG         = 42,
    parameter int         STEP        = 7,
    parameter logic [7:0] MODE_DIRECT = 8'h21,
    parameter logic [7:0] MODE_HUE    = 8'hA4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [7:0]     mode,
    input  logic [W-1:0]   lint,
    input  logic [W-1:0]   colorIdx,
    input  logic [W-1:0]   whiteIn,
    input  logic [W-1:0]   redIn,
    input  logic [W-1:0]   greenIn,
    input  logic [W-1:0]   blueIn,
    input  logic           mult_ok,
    input  logic [2*W-1:0] mult_res,
    output logic [W-1:0]   mult1,
    output logic [W-1:0]   mult2,
    output logic           ld,
    output logic [W-1:0]   redOut,
    output logic [W-1:0]   greenOut,
    output logic [W-1:0]   blueOut,
    output logic [W-1:0]   whiteOut,
    output logic           done
);

    localparam logic [W-1:0] MAX   = '1;
    localparam logic [W-1:0] SEG_W = W'(SEG);
    localparam int           RW    = W + $clog2(SEG * STEP);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SEARCH,
        S_RAMP,
        S_WSAT,
        S_MUL_W,
        S_MUL_R,
        S_MUL_G,
        S_MUL_B,
        S_APPLY
    } state_t;

    state_t         state;
    logic           rst_q;
    logic [7:0]     mode_q;
    logic [W-1:0]   idx_l;
    logic [W-1:0]   lint_l;
    logic [W-1:0]   white_l;
    logic [W-1:0]   rem;
    logic [2:0]     sector;
    logic [W-1:0]   r;
    logic [W-1:0]   g;
    logic [W-1:0]   b;
    logic [W-1:0]   cap_w;
    logic [W-1:0]   cap_r;
    logic [W-1:0]   cap_g;
    logic [W-1:0]   cap_b;
    logic [RW-1:0]  ramp_full;
    logic [W-1:0]   ramp;
    logic [W-1:0]   prod_hi;
    logic           unused_bits;

    function automatic logic [W-1:0] sat_add(input logic [W-1:0] a,
                                             input logic [W-1:0] c);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, c};
        return s[W] ? MAX : s[W-1:0];
    endfunction

    // Ramp within a sector, kept wide until clamped to full scale
    always_comb begin
        ramp_full = RW'(rem) * RW'(STEP);
        ramp      = (ramp_full > RW'(MAX)) ? MAX : ramp_full[W-1:0];
    end

    assign prod_hi     = mult_res[2*W-1:W];
    assign unused_bits = ^{mult_res[W-1:0], idx_l};

    // Reset is registered once before it touches any state
    always_ff @(posedge clk) begin
        rst_q <= reset;
    end

    // Main job sequencer with registered outputs
    always_ff @(posedge clk) begin
        if (!rst_q) begin
            state    <= S_IDLE;
            mode_q   <= 8'h00;
            idx_l    <= '0;
            lint_l   <= '0;
            white_l  <= '0;
            rem      <= '0;
            sector   <= '0;
            r        <= '0;
            g        <= '0;
            b        <= '0;
            cap_w    <= '0;
            cap_r    <= '0;
            cap_g    <= '0;
            cap_b    <= '0;
            mult1    <= '0;
            mult2    <= '0;
            ld       <= 1'b0;
            redOut   <= '0;
            greenOut <= '0;
            blueOut  <= '0;
            whiteOut <= '0;
            done     <= 1'b0;
        end else begin
            mode_q <= mode;
            done   <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (mode_q == MODE_DIRECT) begin
                        whiteOut <= whiteIn;
                        redOut   <= redIn;
                        greenOut <= greenIn;
                        blueOut  <= blueIn;
                    end else if (mode_q == MODE_HUE) begin
                        idx_l   <= colorIdx;
                        lint_l  <= lint;
                        white_l <= whiteIn;
                        rem     <= colorIdx;
                        sector  <= '0;
                        state   <= S_SEARCH;
                    end
                end
                S_SEARCH: begin
                    if (rem >= SEG_W && sector < 3'd6) begin
                        rem    <= rem - SEG_W;
                        sector <= sector + 3'd1;
                    end else begin
                        state <= S_RAMP;
                    end
                end
                S_RAMP: begin
                    case (sector)
                        3'd0: begin r <= MAX;        g <= '0;         b <= ramp;       end
                        3'd1: begin r <= MAX - ramp; g <= '0;         b <= MAX;        end
                        3'd2: begin r <= '0;         g <= ramp;       b <= MAX;        end
                        3'd3: begin r <= '0;         g <= MAX;        b <= MAX - ramp; end
                        3'd4: begin r <= ramp;       g <= MAX;        b <= '0;         end
                        3'd5: begin r <= MAX;        g <= MAX - ramp; b <= '0;         end
                        default: begin r <= MAX;     g <= '0;         b <= '0;         end
                    endcase
                    state <= S_WSAT;
                end
                S_WSAT: begin
                    r     <= sat_add(r, white_l);
                    g     <= sat_add(g, white_l);
                    b     <= sat_add(b, white_l);
                    mult1 <= lint_l;
                    mult2 <= white_l;
                    state <= S_MUL_W;
                end
                S_MUL_W: begin
                    if (ld) begin
                        if (mult_ok) begin
                            cap_w <= prod_hi;
                            ld    <= 1'b0;
                            mult2 <= r;
                            state <= S_MUL_R;
                        end
                    end else if (!mult_ok) begin
                        ld <= 1'b1;
                    end
                end
                S_MUL_R: begin
                    if (ld) begin
                        if (mult_ok) begin
                            cap_r <= prod_hi;
                            ld    <= 1'b0;
                            mult2 <= g;
                            state <= S_MUL_G;
                        end
                    end else if (!mult_ok) begin
                        ld <= 1'b1;
                    end
                end
                S_MUL_G: begin
                    if (ld) begin
                        if (mult_ok) begin
                            cap_g <= prod_hi;
                            ld    <= 1'b0;
                            mult2 <= b;
                            state <= S_MUL_B;
                        end
                    end else if (!mult_ok) begin
                        ld <= 1'b1;
                    end
                end
                S_MUL_B: begin
                    if (ld) begin
                        if (mult_ok) begin
                            cap_b <= prod_hi;
                            ld    <= 1'b0;
                            state <= S_APPLY;
                        end
                    end else if (!mult_ok) begin
                        ld <= 1'b1;
                    end
                end
                S_APPLY: begin
                    whiteOut <= cap_w;
                    redOut   <= cap_r;
                    greenOut <= cap_g;
                    blueOut  <= cap_b;
                    done     <= 1'b1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/color_gen_param.md
# color_gen_param

Parametrised RGBW colour generator, successor to the fixed 8-bit hue-ramp generator in the LED controller datapath. It sits between the command decoder (mode, intensity, colour index, white and direct RGBW inputs) and the PWM stage.

In hue mode it:
- maps a colour index onto a six-sector hue wheel by iterative sector search,
- saturating-adds a white offset,
- scales all four channels by intensity through the shared external multiplier, using a ld/mult_ok handshake.

It adds three things over the previous generation: channel width and wheel geometry are generics, inputs are snapshotted at job start, and a `done` pulse is produced.

## Interface
- W, 8, channel width in bits
- SEG, 42, colour-index steps per hue sector
- STEP, 7, ramp increment per index step
- MODE_DIRECT, 8'h21, mode code for pass-through
- MODE_HUE, 8'hA4, mode code for hue generation

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset; registered once internally before use
- mode  in  8  mode command, registered once (mode_q) before decoding
- lint  in  W  intensity scaler
- colorIdx  in  W  hue index
- whiteIn, redIn, greenIn, blueIn  in  W each  white offset / direct channel values
- mult_ok  in  1  external multiplier result valid
- mult_res  in  2W  external multiplier product
- mult1, mult2  out  W each  multiplier operands
- ld  out  1  multiplier start request
- redOut, greenOut, blueOut, whiteOut  out  W each  channel outputs
- done  out  1  one-cycle pulse when hue-mode outputs update

## Operation
- MAX = 2^W-1.
- Reset (internal registered reset low): state IDLE; all outputs 0 (channels, mult1, mult2, ld, done).
  - Applies from any state, including mid-multiply.
  - Internal r/g/b/sector/rem registers are also cleared.
- IDLE
  - mode_q==MODE_DIRECT: every cycle, copy whiteIn/redIn/greenIn/blueIn to outputs; stay in IDLE.
  - mode_q==MODE_HUE: latch idx_l=colorIdx, lint_l=lint, white_l=whiteIn; set rem=colorIdx, sector=0; go to SEARCH.
  - Any other mode: hold outputs, stay in IDLE.
- SEARCH: each cycle, if rem>=SEG and sector<6, then rem-=SEG and sector++; otherwise go to RAMP. Takes at most 7 cycles.
- RAMP: ramp = min(rem*STEP, MAX), computed at width W+log2(SEG*STEP) with no truncation before the clamp. Then go to WSAT.
  - sector 0: R=MAX, G=0, B=ramp
  - sector 1: R=MAX-ramp (floor 0), G=0, B=MAX
  - sector 2: R=0, G=ramp, B=MAX
  - sector 3: R=0, G=MAX, B=MAX-ramp
  - sector 4: R=ramp, G=MAX, B=0
  - sector 5: R=MAX, G=MAX-ramp, B=0
  - sector 6 (index beyond 6*SEG): R=MAX, G=0, B=0
- WSAT: each of r,g,b = min(x+white_l, MAX), computed at W+1 bits. Then go to MUL_W.
- MUL_W, MUL_R, MUL_G, MUL_B
  - Operands: mult1=lint_l; mult2 = white_l / r / g / b respectively.
  - Captured result: mult_res[2W-1:W], i.e. product>>W.
  - Handshake:
    - ld rises only in a cycle where mult_ok==0 and ld==0. A stale mult_ok high blocks ld.
    - While ld==1, wait for mult_ok==1.
    - On mult_ok==1: capture, drop ld, advance to the next state.
    - The next channel again waits for mult_ok==0 before raising ld.
  - Order after MUL_B: APPLY.
- APPLY
  - All four outputs update simultaneously from the captured values.
  - done=1 for this cycle only.
  - Go to IDLE. In IDLE with mode_q still MODE_HUE, a new job starts on the next cycle.
- Mode is not sampled outside IDLE: a change mid-job takes effect after APPLY.
- Outputs never show partial results.

## Timing
- Direct mode latency: input change visible on outputs 1 cycle after capture; mode change to visible is 2 cycles (mode_q + output register).
- Hue job, multiplier replies k cycles after ld: 1 (IDLE) + (sector+1) SEARCH + 1 RAMP + 1 WSAT + 4*(k+2) + 1 APPLY.
- Inputs changing after the IDLE latch cycle do not affect the job in progress.
- ld, mult1 and mult2 are registered. mult1/mult2 are stable from the cycle before ld rises until capture.

## Test plan
Parameters: W=8, SEG=42, STEP=7, multiplier model with k=2 that drops mult_ok when ld falls.

1. Direct mode: mode=0x21, W/R/G/B = 0x10/0x20/0x30/0x40 -> outputs match 2 cycles after mode is applied; done stays 0.
2. Hue sector 0: mode=0xA4, idx=21, white=0, lint=0xFF -> R=0xFE, G=0x00, B=0x92, W=0x00, with a single done pulse.
3. Hue with white saturation: idx=100 (sector 2, ramp 0x70), white=0xA0, lint=0x80 -> R=0x50, G=0x7F, B=0x7F, W=0x50.
4. Boundaries:
   - idx=41 -> ramp clamps to 0xFF; with lint=0xFF, B=0xFE.
   - idx=0xFE -> sector 6; with lint=0xFF, R=0xFE, G=0, B=0.
   - idx=0 -> R=0xFE, G=0, B=0.
5. Stale handshake: mult_ok held high 5 cycles on entry to MUL_W -> ld stays 0 until mult_ok drops; final values unchanged vs scenario 2.
6. Reset mid-job: reset low during MUL_G -> 1 cycle later (after internal registration) all outputs 0, ld=0, done=0. Release with mode=0x13 -> remains in IDLE, outputs stay 0.
